// File: rtl/riscv_defines_pkg.sv
// ---------------------------------------------------------------------------
// riscv_defines_pkg
// Shared definitions for the RV32I core.
//   DATA_WIDTH    : datapath / address width
//   INSTR_BYTES   : size of one instruction word, used as the sequential PC step
//   fetch_state_e : states of the instruction-fetch sequencer (fetch_ctrl)
// ---------------------------------------------------------------------------
package riscv_defines_pkg;

    localparam int DATA_WIDTH  = 32;
    localparam int INSTR_BYTES = 4;

    typedef enum logic [2:0] {
        IDLE,   // one cycle after reset before the first request
        REQ,    // request offered to instruction memory
        WAIT,   // request accepted, waiting for the response
        HOLD,   // instruction presented to decode
        ERR     // misaligned target or memory timeout; no requests
    } fetch_state_e;

endpackage

// File: rtl/fetch_ctrl_pc.sv
// ---------------------------------------------------------------------------
// pc
// Program-counter register. Loads next_pc when we is high, otherwise holds.
//   clk        : clock
//   rst_n      : asynchronous reset, active-low (clears the PC to 0)
//   we         : write enable
//   next_pc    : value loaded when we=1
//   current_pc : registered program counter
// ---------------------------------------------------------------------------
module pc
    import riscv_defines_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  we,
    input  logic [DATA_WIDTH-1:0] next_pc,
    output logic [DATA_WIDTH-1:0] current_pc
);

    logic [DATA_WIDTH-1:0] pc_d;
    logic [DATA_WIDTH-1:0] pc_q;

    // NOTE: every signal written in always_comb gets a value on every path
    // (here via the conditional); a missing branch would infer a latch.
    always_comb begin
        pc_d = we ? next_pc : pc_q;
    end

    // NOTE: flops use non-blocking assignments so all registers update from
    // the same pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q <= '0;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign current_pc = pc_q;

endmodule

// File: rtl/fetch_ctrl.sv
// ---------------------------------------------------------------------------
// fetch_ctrl
// Instruction-fetch sequencer. Owns the PC (via the pc register), issues one
// request at a time to instruction memory, hands instructions to decode,
// applies redirects from execute and flags misaligned targets / timeouts.
//   clk, rst_n                         : clock, async active-low reset
//   redirect_valid / redirect_pc       : taken branch/jump from execute
//   imem_req_valid/_addr/_ready        : request channel to instruction memory
//   imem_rsp_valid / imem_rsp_data     : response from instruction memory
//   if_valid / if_instr / if_pc        : instruction to decode
//   if_ready                           : decode accepts the instruction
//   fetch_err                          : sticky misaligned/timeout error
// ---------------------------------------------------------------------------
module fetch_ctrl
    import riscv_defines_pkg::*;
#(
    parameter int unsigned IMEM_TIMEOUT = 255
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  redirect_valid,
    input  logic [DATA_WIDTH-1:0] redirect_pc,
    output logic                  imem_req_valid,
    output logic [DATA_WIDTH-1:0] imem_req_addr,
    input  logic                  imem_req_ready,
    input  logic                  imem_rsp_valid,
    input  logic [DATA_WIDTH-1:0] imem_rsp_data,
    output logic                  if_valid,
    output logic [DATA_WIDTH-1:0] if_instr,
    output logic [DATA_WIDTH-1:0] if_pc,
    input  logic                  if_ready,
    output logic                  fetch_err
);

    localparam logic [15:0] TIMEOUT_CNT = 16'(IMEM_TIMEOUT);

    fetch_state_e          state_d, state_q;
    logic                  kill_d, kill_q;          // outstanding response must be dropped
    logic                  err_pend_d, err_pend_q;  // enter ERR once the dropped response drains
    logic [15:0]           cnt_d, cnt_q;
    logic [DATA_WIDTH-1:0] req_addr_d, req_addr_q;
    logic                  req_valid_d, req_valid_q;
    logic                  if_valid_d, if_valid_q;
    logic [DATA_WIDTH-1:0] if_instr_d, if_instr_q;
    logic [DATA_WIDTH-1:0] if_pc_d, if_pc_q;
    logic                  fetch_err_d, fetch_err_q;

    logic                  pc_we;
    logic [DATA_WIDTH-1:0] pc_next;
    logic [DATA_WIDTH-1:0] current_pc;
    logic                  redir;
    logic                  misaligned;

    pc u_pc (
        .clk        (clk),
        .rst_n      (rst_n),
        .we         (pc_we),
        .next_pc    (pc_next),
        .current_pc (current_pc)
    );

    assign redir      = redirect_valid && (state_q != IDLE);
    assign misaligned = (redirect_pc[1:0] != 2'b00);

    always_comb begin
        state_d     = state_q;
        kill_d      = kill_q;
        err_pend_d  = err_pend_q;
        cnt_d       = cnt_q;
        req_addr_d  = req_addr_q;
        if_instr_d  = if_instr_q;
        if_pc_d     = if_pc_q;
        fetch_err_d = fetch_err_q;
        pc_we       = 1'b0;
        pc_next     = current_pc;

        // A redirect always lands in the PC and wins over the +4 step below.
        if (redir) begin
            pc_we   = 1'b1;
            pc_next = redirect_pc;
        end

        unique case (state_q)
            IDLE: state_d = REQ;

            REQ: begin
                if (imem_req_ready) begin
                    state_d = WAIT;
                    cnt_d   = '0;
                end
                // The request stays (or already went) out at the old address.
                if (redir) begin
                    kill_d     = 1'b1;
                    err_pend_d = misaligned;
                end
            end

            WAIT: begin
                cnt_d = cnt_q + 16'd1;
                if (imem_rsp_valid) begin
                    if (redir || kill_q) begin
                        // Response is stale: drop it; nothing is outstanding now.
                        kill_d     = 1'b0;
                        err_pend_d = 1'b0;
                        if (redir ? misaligned : err_pend_q) begin
                            state_d     = ERR;
                            fetch_err_d = 1'b1;
                        end else begin
                            state_d = REQ;
                        end
                    end else begin
                        if_instr_d = imem_rsp_data;
                        if_pc_d    = req_addr_q;
                        state_d    = HOLD;
                    end
                end else if (cnt_q + 16'd1 == TIMEOUT_CNT) begin
                    // Memory guarantees silence after a timeout, so nothing
                    // remains outstanding and no kill is carried into ERR.
                    state_d     = ERR;
                    fetch_err_d = 1'b1;
                    kill_d      = 1'b0;
                    err_pend_d  = 1'b0;
                end else if (redir) begin
                    kill_d     = 1'b1;
                    err_pend_d = misaligned;
                end
            end

            HOLD: begin
                if (redir) begin
                    if (misaligned) begin
                        state_d     = ERR;
                        fetch_err_d = 1'b1;
                    end else begin
                        state_d = REQ;
                    end
                end else if (if_ready) begin
                    pc_we   = 1'b1;
                    pc_next = current_pc + DATA_WIDTH'(INSTR_BYTES);
                    state_d = REQ;
                end
            end

            ERR: begin
                if (redir) begin
                    if (misaligned) begin
                        fetch_err_d = 1'b1;
                    end else begin
                        fetch_err_d = 1'b0;
                        cnt_d       = '0;
                        state_d     = kill_q ? WAIT : REQ;
                    end
                end
            end

            default: state_d = IDLE;
        endcase

        // The request address is captured on REQ entry from the PC value that
        // will be current after this edge, so redirects/increments are seen.
        if (state_d == REQ && state_q != REQ) begin
            req_addr_d = pc_we ? pc_next : current_pc;
        end

        req_valid_d = (state_d == REQ);
        if_valid_d  = (state_d == HOLD);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            kill_q      <= 1'b0;
            err_pend_q  <= 1'b0;
            cnt_q       <= '0;
            req_addr_q  <= '0;
            req_valid_q <= 1'b0;
            if_valid_q  <= 1'b0;
            if_instr_q  <= '0;
            if_pc_q     <= '0;
            fetch_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            kill_q      <= kill_d;
            err_pend_q  <= err_pend_d;
            cnt_q       <= cnt_d;
            req_addr_q  <= req_addr_d;
            req_valid_q <= req_valid_d;
            if_valid_q  <= if_valid_d;
            if_instr_q  <= if_instr_d;
            if_pc_q     <= if_pc_d;
            fetch_err_q <= fetch_err_d;
        end
    end

    assign imem_req_valid = req_valid_q;
    assign imem_req_addr  = req_addr_q;
    assign if_valid       = if_valid_q;
    assign if_instr       = if_instr_q;
    assign if_pc          = if_pc_q;
    assign fetch_err      = fetch_err_q;

endmodule
